// File: rtl/sym_upsampler_if.sv
// Byte-in / sample-out bus for the symbol upsampler.
// The slave side is the upsampler; the master side drives data bytes and sinks samples.
interface sym_upsampler_if #(
  parameter int unsigned W = 16
);
  logic         mode_i;
  logic [7:0]   d_i;
  logic         d_valid_i;
  logic         d_ready_o;
  logic [W-1:0] y_a_o;
  logic [W-1:0] y_b_o;
  logic         y_valid_o;
  logic         y_ready_i;
  logic         underrun_o;

  modport master (
    output mode_i, d_i, d_valid_i, y_ready_i,
    input  d_ready_o, y_a_o, y_b_o, y_valid_o, underrun_o
  );

  modport slave (
    input  mode_i, d_i, d_valid_i, y_ready_i,
    output d_ready_o, y_a_o, y_b_o, y_valid_o, underrun_o
  );
endinterface

// File: rtl/sym_upsampler.sv
// BPSK/QPSK symbol mapper with zero-stuffing upsampler.
// One byte is buffered and shifted out LSB first, one symbol per OSR output samples.
// The symbol lands on phase 0 of each group; phases 1..OSR-1 carry zeros.
module sym_upsampler #(
  parameter int unsigned         W   = 16,
  parameter int unsigned         OSR = 8,
  parameter logic signed [W-1:0] AMP = 1
) (
  input logic            clk,
  input logic            rst,
  sym_upsampler_if.slave bus
);

  localparam int unsigned    PhW    = $clog2(OSR);
  localparam logic [PhW-1:0] PhLast = PhW'(OSR - 1);
  localparam logic [W-1:0]   PosAmp = AMP;
  localparam logic [W-1:0]   NegAmp = -AMP;

  logic [7:0]     r_buf;
  logic [3:0]     r_bits_left;
  logic           r_mode;
  logic           r_d_ready;
  logic           r_started;
  logic           r_arm;
  logic           r_y_valid;
  logic [W-1:0]   r_y_a;
  logic [W-1:0]   r_y_b;
  logic           r_underrun;
  logic [PhW-1:0] r_phase;

  logic           w_accept;
  logic           w_xfer;
  logic           w_init;
  logic           w_load;
  logic           w_sym;
  logic [PhW-1:0] w_phase_nxt;
  logic [7:0]     w_buf_d;
  logic [3:0]     w_bits_d;
  logic           w_mode_d;
  logic [W-1:0]   w_y_a_d;
  logic [W-1:0]   w_y_b_d;
  logic           w_underrun_d;
  logic [PhW-1:0] w_phase_d;

  function automatic logic [W-1:0] map_bit(input logic b);
    return b ? NegAmp : PosAmp;
  endfunction

  // Next-state: byte accept, sample load and bit consumption at phase 0.
  always_comb begin
    w_accept     = bus.d_valid_i & r_d_ready;
    w_xfer       = r_y_valid & bus.y_ready_i;
    // First sample after the first byte is loaded without a transfer.
    w_init       = r_arm;
    w_load       = w_xfer | w_init;
    w_phase_nxt  = (w_init || r_phase == PhLast) ? '0 : r_phase + 1'b1;
    w_sym        = w_load & (w_phase_nxt == '0);

    w_buf_d      = r_buf;
    w_bits_d     = r_bits_left;
    w_mode_d     = r_mode;
    w_y_a_d      = r_y_a;
    w_y_b_d      = r_y_b;
    w_underrun_d = 1'b0;
    w_phase_d    = w_load ? w_phase_nxt : r_phase;

    if (w_load) begin
      w_y_a_d = '0;
      w_y_b_d = '0;
    end

    if (w_sym) begin
      if (r_bits_left == 4'd0) begin
        w_underrun_d = 1'b1;
      end else if (!r_mode) begin
        w_y_a_d  = map_bit(r_buf[0]);
        w_buf_d  = {1'b0, r_buf[7:1]};
        w_bits_d = r_bits_left - 4'd1;
      end else begin
        w_y_a_d  = map_bit(r_buf[0]);
        w_y_b_d  = map_bit(r_buf[1]);
        w_buf_d  = {2'b00, r_buf[7:2]};
        w_bits_d = r_bits_left - 4'd2;
      end
    end

    // d_ready_o implies an empty buffer, so accept never collides with consumption.
    if (w_accept) begin
      w_buf_d  = bus.d_i;
      w_bits_d = 4'd8;
      w_mode_d = bus.mode_i;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf       <= '0;
      r_bits_left <= '0;
      r_mode      <= 1'b0;
      r_d_ready   <= 1'b0;
      r_started   <= 1'b0;
      r_arm       <= 1'b0;
      r_y_valid   <= 1'b0;
      r_y_a       <= '0;
      r_y_b       <= '0;
      r_underrun  <= 1'b0;
      r_phase     <= '0;
    end else begin
      r_buf       <= w_buf_d;
      r_bits_left <= w_bits_d;
      r_mode      <= w_mode_d;
      r_d_ready   <= (w_bits_d == 4'd0);
      r_started   <= r_started | w_accept;
      // One-cycle delay between accept and the initial load.
      r_arm       <= r_started & ~r_arm & ~r_y_valid;
      r_y_valid   <= r_y_valid | r_arm;
      r_y_a       <= w_y_a_d;
      r_y_b       <= w_y_b_d;
      r_underrun  <= w_underrun_d;
      r_phase     <= w_phase_d;
    end
  end

  assign bus.d_ready_o  = r_d_ready;
  assign bus.y_a_o      = r_y_a;
  assign bus.y_b_o      = r_y_b;
  assign bus.y_valid_o  = r_y_valid;
  assign bus.underrun_o = r_underrun;

endmodule

// File: tb/tb_sym_upsampler.sv
// Directed bench for sym_upsampler (W=16, OSR=8, AMP=1) with hand-built symbol tables.
module tb_sym_upsampler;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [15:0] sym_a [8];
  logic [15:0] sym_b [8];
  int          n_sym;

  sym_upsampler_if #(.W(16)) u_bus ();

  sym_upsampler #(
    .W   (16),
    .OSR (8),
    .AMP (16'sd1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] exp_a(input int k);
    if (k % 8 != 0) return 16'h0;
    if (k / 8 < n_sym) return sym_a[k/8];
    return 16'h0;
  endfunction

  function automatic logic [15:0] exp_b(input int k);
    if (k % 8 != 0) return 16'h0;
    if (k / 8 < n_sym) return sym_b[k/8];
    return 16'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    u_bus.d_valid_i = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Offer a byte until accepted, then wait out the two-edge latency to sample 0.
  task automatic send_byte(input logic m, input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    u_bus.mode_i    = m;
    u_bus.d_i       = b;
    u_bus.d_valid_i = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (u_bus.d_ready_o) acc = 1'b1;
      step();
    end
    u_bus.d_valid_i = 1'b0;
    if (!acc) check_eq("accept_timeout", 32'd0, 32'd1);
    check_eq("rdy_after_accept", 32'(u_bus.d_ready_o), 32'd0);
    check_eq("valid_e0", 32'(u_bus.y_valid_o), 32'd0);
    step();
    check_eq("valid_e1", 32'(u_bus.y_valid_o), 32'd0);
    step();
  endtask

  // Walk n_samp samples, stalling stall_len cycles when sample stall_k is shown.
  task automatic run_stream(input int n_samp, input int stall_k, input int stall_len);
    int   k;
    int   stalls;
    logic fresh;
    k = 0;
    stalls = 0;
    fresh = 1'b1;
    while (k < n_samp) begin
      check_eq($sformatf("y_a[%0d]", k), 32'(u_bus.y_a_o), 32'(exp_a(k)));
      check_eq($sformatf("y_b[%0d]", k), 32'(u_bus.y_b_o), 32'(exp_b(k)));
      check_eq($sformatf("valid[%0d]", k), 32'(u_bus.y_valid_o), 32'd1);
      check_eq($sformatf("under[%0d]", k), 32'(u_bus.underrun_o),
               32'(fresh && (k % 8 == 0) && (k / 8 >= n_sym)));
      check_eq($sformatf("rdy[%0d]", k), 32'(u_bus.d_ready_o),
               32'(k >= (n_sym - 1) * 8));
      if (k == stall_k && stalls < stall_len) begin
        u_bus.y_ready_i = 1'b0;
        stalls++;
      end else begin
        u_bus.y_ready_i = 1'b1;
      end
      step();
      if (u_bus.y_ready_i) begin
        k++;
        fresh = 1'b1;
      end else begin
        fresh = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    u_bus.mode_i    = 1'b0;
    u_bus.d_i       = 8'hA5;
    u_bus.d_valid_i = 1'b1;
    u_bus.y_ready_i = 1'b1;
    n_sym = 0;

    // Reset held 3 cycles with data offered: nothing accepted, all outputs idle.
    repeat (3) begin
      step();
      check_eq("rst_rdy", 32'(u_bus.d_ready_o), 32'd0);
      check_eq("rst_valid", 32'(u_bus.y_valid_o), 32'd0);
      check_eq("rst_a", 32'(u_bus.y_a_o), 32'd0);
      check_eq("rst_b", 32'(u_bus.y_b_o), 32'd0);
      check_eq("rst_under", 32'(u_bus.underrun_o), 32'd0);
    end
    rst = 1'b0;
    u_bus.d_valid_i = 1'b0;
    step();
    check_eq("post_rst_rdy", 32'(u_bus.d_ready_o), 32'd1);
    check_eq("post_rst_valid", 32'(u_bus.y_valid_o), 32'd0);
    repeat (3) step();
    check_eq("idle_valid", 32'(u_bus.y_valid_o), 32'd0);

    // BPSK 0x0F, continuous ready, then starve into an underrun at sample 64.
    sym_a = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
              16'h0001, 16'h0001, 16'h0001, 16'h0001};
    sym_b = '{default: 16'h0000};
    n_sym = 8;
    send_byte(1'b0, 8'h0F);
    run_stream(66, -1, 0);

    // QPSK 0xB4: (+1,+1) (-1,+1) (-1,-1) (+1,-1), buffer empties on the 4th symbol.
    do_reset();
    sym_a = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0};
    sym_b = '{16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0};
    n_sym = 4;
    send_byte(1'b1, 8'hB4);
    run_stream(33, -1, 0);

    // BPSK 0x0F with a 5-cycle stall while symbol 1 is on the output.
    do_reset();
    sym_a = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
              16'h0001, 16'h0001, 16'h0001, 16'h0001};
    sym_b = '{default: 16'h0000};
    n_sym = 8;
    send_byte(1'b0, 8'h0F);
    run_stream(64, 8, 5);

    // Reset while the 3rd symbol of 0x55 is shown, then restart with 0x02.
    do_reset();
    sym_a = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001,
              16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};
    sym_b = '{default: 16'h0000};
    n_sym = 8;
    send_byte(1'b0, 8'h55);
    run_stream(16, -1, 0);
    check_eq("pre_rst_a", 32'(u_bus.y_a_o), 32'h0000FFFF);
    rst = 1'b1;
    step();
    check_eq("mid_rst_a", 32'(u_bus.y_a_o), 32'd0);
    check_eq("mid_rst_b", 32'(u_bus.y_b_o), 32'd0);
    check_eq("mid_rst_valid", 32'(u_bus.y_valid_o), 32'd0);
    check_eq("mid_rst_rdy", 32'(u_bus.d_ready_o), 32'd0);
    step();
    rst = 1'b0;
    step();
    check_eq("rst2_rdy", 32'(u_bus.d_ready_o), 32'd1);
    check_eq("rst2_valid", 32'(u_bus.y_valid_o), 32'd0);
    sym_a = '{16'h0001, 16'hFFFF, 16'h0001, 16'h0001,
              16'h0001, 16'h0001, 16'h0001, 16'h0001};
    send_byte(1'b0, 8'h02);
    run_stream(17, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sym_upsampler.md
SYM_UPSAMPLER -- requirements
Module: sym_upsampler

Interface
REQ-001 SHALL have parameter W, default 16: output sample width (two's complement).
REQ-002 SHALL have parameter OSR, default 8: output samples per symbol (legal range 2..256).
REQ-003 SHALL have parameter AMP, default 1: symbol magnitude, signed W-bit.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port mode_i  input  1  0 = BPSK (1 bit/symbol), 1 = QPSK (2 bits/symbol).
REQ-007 SHALL have port d_i  input  8  data byte, transmitted LSB first.
REQ-008 SHALL have port d_valid_i  input  1  d_i valid.
REQ-009 SHALL have port d_ready_o  output  1  byte buffer empty; accept when d_valid_i & d_ready_o.
REQ-010 SHALL have port y_a_o  output  W  in-phase sample, feeds pulse-shaping filter x_a_i.
REQ-011 SHALL have port y_b_o  output  W  quadrature sample, feeds filter x_b_i.
REQ-012 SHALL have port y_valid_o  output  1  sample valid.
REQ-013 SHALL have port y_ready_i  input  1  downstream ready; transfer when y_valid_o & y_ready_i.
REQ-014 SHALL have port underrun_o  output  1  one-cycle pulse: symbol slot found no data.

Function
REQ-015 SHALL hold one byte in a shift buffer with bit counter bits_left (0..8); d_ready_o registered, 1 iff bits_left == 0 and not in reset.
REQ-016 SHALL, on accept, load d_i, set bits_left = 8, latch mode_i for that byte, clear d_ready_o at the same edge.
REQ-017 SHALL keep y_valid_o = 0 until the first byte is accepted; thereafter y_valid_o = 1 continuously until reset.
REQ-018 SHALL present the first sample (phase 0, first symbol of first byte) on the 2nd rising edge after the accepting edge.
REQ-019 SHALL keep a phase counter 0..OSR-1, advancing (wrap OSR-1 -> 0) only on an output transfer.
REQ-020 SHALL load the output register only on a transfer (or the initial load of REQ-018); outputs stable while y_ready_i = 0.
REQ-021 SHALL output zero on both y_a_o and y_b_o for phases 1..OSR-1.
REQ-022 SHALL, at phase 0, consume bits from buffer bit 0: BPSK consumes 1 bit, a = map(bit), b = 0; QPSK consumes 2 bits, a = map(even bit), b = map(odd bit).
REQ-023 SHALL map bit 0 -> +AMP, bit 1 -> -AMP, sign-correct at width W.
REQ-024 SHALL decrement bits_left by bits consumed; on reaching 0 set d_ready_o = 1 at the same edge.
REQ-025 SHALL, if bits_left == 0 when a phase-0 sample is loaded, output a = b = 0, pulse underrun_o for one cycle, and keep y_valid_o = 1 and phase counting.
REQ-026 SHALL not accept a new byte in the same cycle bits are consumed (d_ready_o is registered); OSR >= 2 guarantees a refill slot between symbols.

Reset
REQ-027 SHALL, while rst = 1, force y_a_o = 0, y_b_o = 0, y_valid_o = 0, underrun_o = 0, d_ready_o = 0, bits_left = 0, phase = 0, started flag = 0.
REQ-028 SHALL, on reset mid-operation, discard buffered bits and in-progress sample; d_ready_o = 1 one cycle after rst deasserts.
REQ-029 SHALL ignore d_valid_i and y_ready_i while rst = 1.

Verification
REQ-030 SHALL cover: rst high 3 cycles, d_valid_i = 1 -> d_ready_o = 0, y_valid_o = 0, outputs 0, no byte accepted.
REQ-031 SHALL cover: BPSK, OSR = 8, AMP = 1, byte 0x0F, y_ready_i = 1 -> y_a at samples 0/8/16/24 = 0xFFFF, 32/40/48/56 = 0x0001, all else 0, y_b all 0.
REQ-032 SHALL cover: QPSK byte 0xB4 -> phase-0 (a,b) = (+1,+1), (-1,+1), (-1,-1), (+1,-1), then d_ready_o = 1 after the 4th symbol.
REQ-033 SHALL cover: y_ready_i low 5 cycles mid-symbol -> outputs and phase frozen, full sample sequence identical to REQ-031.
REQ-034 SHALL cover: one BPSK byte then d_valid_i = 0 -> sample 64 = 0, underrun_o high exactly 1 cycle, y_valid_o stays 1.
REQ-035 SHALL cover: rst pulsed during 3rd symbol of a byte -> outputs zero, y_valid_o = 0, next byte restarts at phase 0 with its bit 0.
